fu_wb_arbiter: RTL and testbench



---
 rtl/fu_wb_arbiter_pkg.sv | 21 ++
 rtl/fu_wb_arbiter_rr_port_alloc.sv | 42 ++++
 rtl/fu_wb_arbiter.sv | 137 +++++++++++++
 tb/tb_fu_wb_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fu_wb_arbiter_pkg.sv
// Shared types and defaults for the FU writeback arbiter.
// Optional perf counters are enabled by defining FU_WB_ARB_PERF_EN.
package fu_wb_arbiter_pkg;

  localparam int unsigned TRANS_ID_BITS = 3;
  localparam int unsigned DATA_WIDTH    = 64;
  localparam int unsigned NR_WB_PORTS   = 2;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]    result;
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic                     ex_valid;
    logic [63:0]              ex_cause;
  } wb_entry_t;

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fu_wb_arbiter_rr_port_alloc.sv
// Combinational rotating-priority allocator: grants the first NrWbPorts
// non-empty FIFOs, scanning from rr, to ports 0, 1, ... in scan order.
module fu_wb_arbiter_rr_port_alloc
  import fu_wb_arbiter_pkg::*;
#(
  parameter int unsigned NrFu      = 4,
  parameter int unsigned NrWbPorts = NR_WB_PORTS,
  localparam int unsigned IdxW     = idx_width(NrFu)
) (
  input  logic [NrFu-1:0]                 nonempty,
  input  logic [IdxW-1:0]                 rr,
  output logic [NrWbPorts-1:0][IdxW-1:0]  gnt_idx,
  output logic [NrWbPorts-1:0]            gnt_valid,
  output logic [NrFu-1:0]                 pop,
  output logic [IdxW-1:0]                 rr_next
);

  localparam int unsigned PortW = idx_width(NrWbPorts);
  localparam int unsigned PCntW = $clog2(NrWbPorts + 1);

  always_comb begin
    logic [IdxW-1:0]  idx;
    logic [PCntW-1:0] port;
    gnt_idx   = '0;
    gnt_valid = '0;
    pop       = '0;
    rr_next   = rr;
    idx       = rr;
    port      = '0;
    for (int unsigned k = 0; k < NrFu; k++) begin
      if (nonempty[idx] && (32'(port) < NrWbPorts)) begin
        pop[idx]                   = 1'b1;
        gnt_valid[port[PortW-1:0]] = 1'b1;
        gnt_idx[port[PortW-1:0]]   = idx;
        rr_next = (32'(idx) == NrFu - 1) ? '0 : idx + 1'b1;
        port    = port + 1'b1;
      end
      idx = (32'(idx) == NrFu - 1) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/fu_wb_arbiter.sv
// Writeback arbiter: per-FU result FIFOs drained onto NrWbPorts write ports.
// Define FU_WB_ARB_PERF_EN to add wb_conflict_o / wb_conflict_cnt_o.
module fu_wb_arbiter
  import fu_wb_arbiter_pkg::*;
#(
  parameter int unsigned NrFu        = 4,
  parameter int unsigned NrWbPorts   = NR_WB_PORTS,
  parameter int unsigned BufDepth    = 2,
  parameter int unsigned DataWidth   = DATA_WIDTH,
  parameter int unsigned TransIdBits = TRANS_ID_BITS,
  localparam int unsigned IdxW       = idx_width(NrFu)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  flush_i,
  input  logic [NrFu-1:0]                       fu_valid_i,
  output logic [NrFu-1:0]                       fu_ready_o,
  input  logic [NrFu-1:0][DataWidth-1:0]        fu_result_i,
  input  logic [NrFu-1:0][TransIdBits-1:0]      fu_trans_id_i,
  input  logic [NrFu-1:0]                       fu_ex_valid_i,
  input  logic [NrFu-1:0][63:0]                 fu_ex_cause_i,
  output logic [NrWbPorts-1:0]                  wb_valid_o,
  output logic [NrWbPorts-1:0][DataWidth-1:0]   wb_result_o,
  output logic [NrWbPorts-1:0][TransIdBits-1:0] wb_trans_id_o,
  output logic [NrWbPorts-1:0]                  wb_ex_valid_o,
  output logic [NrWbPorts-1:0][63:0]            wb_ex_cause_o,
  output logic [NrWbPorts-1:0][IdxW-1:0]        wb_fu_idx_o
`ifdef FU_WB_ARB_PERF_EN
  ,
  output logic                                  wb_conflict_o,
  output logic [31:0]                           wb_conflict_cnt_o
`endif
);

  localparam int unsigned PtrW = idx_width(BufDepth);
  localparam int unsigned CntW = $clog2(BufDepth + 1);

  typedef struct packed {
    logic [DataWidth-1:0]   result;
    logic [TransIdBits-1:0] trans_id;
    logic                   ex_valid;
    logic [63:0]            ex_cause;
  } entry_t;

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (32'(p) == BufDepth - 1) ? '0 : p + 1'b1;
  endfunction

  entry_t [NrFu-1:0]              head;
  logic [NrFu-1:0]                nonempty, push, pop;
  logic [IdxW-1:0]                rr_q, rr_d;
  logic [NrWbPorts-1:0][IdxW-1:0] gnt_idx;
  logic [NrWbPorts-1:0]           gnt_valid;

  for (genvar n = 0; n < NrFu; n++) begin : g_fifo
    entry_t          mem_q [BufDepth];
    logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0] cnt_q;
    entry_t          wdata;

    assign wdata = '{result:   fu_result_i[n],   trans_id: fu_trans_id_i[n],
                     ex_valid: fu_ex_valid_i[n], ex_cause: fu_ex_cause_i[n]};
    // Ready comes from occupancy only, so a full FIFO stays not-ready while it pops.
    assign fu_ready_o[n] = (cnt_q != CntW'(BufDepth));
    assign nonempty[n]   = (cnt_q != '0);
    assign push[n]       = fu_valid_i[n] & fu_ready_o[n] & ~flush_i;
    assign head[n]       = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        cnt_q    <= '0;
      end else if (flush_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        if (push[n]) wr_ptr_q <= ptr_inc(wr_ptr_q);
        if (pop[n])  rd_ptr_q <= ptr_inc(rd_ptr_q);
        if (push[n] && !pop[n])      cnt_q <= cnt_q + 1'b1;
        else if (!push[n] && pop[n]) cnt_q <= cnt_q - 1'b1;
      end
    end

    // Storage is qualified by cnt_q, so it needs no reset.
    always_ff @(posedge clk_i) begin
      if (push[n]) mem_q[wr_ptr_q] <= wdata;
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    fu_valid_i[n] |-> fu_ready_o[n]);
  end

  fu_wb_arbiter_rr_port_alloc #(
    .NrFu      (NrFu),
    .NrWbPorts (NrWbPorts)
  ) u_alloc (
    .nonempty  (nonempty),
    .rr        (rr_q),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .pop       (pop),
    .rr_next   (rr_d)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      rr_q <= '0;
    else if (flush_i) rr_q <= '0;
    else              rr_q <= rr_d;
  end

  for (genvar p = 0; p < NrWbPorts; p++) begin : g_port
    entry_t sel;
    assign sel              = gnt_valid[p] ? head[gnt_idx[p]] : '0;
    assign wb_valid_o[p]    = gnt_valid[p];
    assign wb_result_o[p]   = sel.result;
    assign wb_trans_id_o[p] = sel.trans_id;
    assign wb_ex_valid_o[p] = sel.ex_valid;
    assign wb_ex_cause_o[p] = sel.ex_cause;
    assign wb_fu_idx_o[p]   = gnt_idx[p];
  end

`ifdef FU_WB_ARB_PERF_EN
  logic [31:0] conflict_cnt_q;

  assign wb_conflict_o     = ($countones(nonempty) > NrWbPorts);
  assign wb_conflict_cnt_o = conflict_cnt_q;

  // Cleared by reset only; flush deliberately leaves it alone.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) conflict_cnt_q <= '0;
    else if (wb_conflict_o && (conflict_cnt_q != '1)) conflict_cnt_q <= conflict_cnt_q + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fu_wb_arbiter.sv
// Directed bench for fu_wb_arbiter: vector table plus multi-cycle sequences
// (contention, back-pressure, fairness, flush, reset mid-stream).
module tb_fu_wb_arbiter;

  logic clk = 1'b0;
  logic rst_ni, flush;

  logic [3:0]       fu_valid, fu_ready, fu_exv;
  logic [3:0][63:0] fu_result, fu_exc;
  logic [3:0][2:0]  fu_id;
  logic [1:0]       wb_valid, wb_exv;
  logic [1:0][63:0] wb_result, wb_exc;
  logic [1:0][2:0]  wb_id;
  logic [1:0][1:0]  wb_idx;

  logic             flush1;
  logic [2:0]       f1_valid, f1_ready, f1_exv;
  logic [2:0][63:0] f1_result, f1_exc;
  logic [2:0][2:0]  f1_id;
  logic [0:0]       w1_valid, w1_exv;
  logic [0:0][63:0] w1_result, w1_exc;
  logic [0:0][2:0]  w1_id;
  logic [0:0][1:0]  w1_idx;

`ifdef FU_WB_ARB_PERF_EN
  logic        conflict, conflict1;
  logic [31:0] conflict_cnt, conflict_cnt1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fu_wb_arbiter #(.NrFu(4), .NrWbPorts(2), .BufDepth(2), .DataWidth(64), .TransIdBits(3)) u_dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush),
    .fu_valid_i(fu_valid), .fu_ready_o(fu_ready), .fu_result_i(fu_result),
    .fu_trans_id_i(fu_id), .fu_ex_valid_i(fu_exv), .fu_ex_cause_i(fu_exc),
    .wb_valid_o(wb_valid), .wb_result_o(wb_result), .wb_trans_id_o(wb_id),
    .wb_ex_valid_o(wb_exv), .wb_ex_cause_o(wb_exc), .wb_fu_idx_o(wb_idx)
`ifdef FU_WB_ARB_PERF_EN
    , .wb_conflict_o(conflict), .wb_conflict_cnt_o(conflict_cnt)
`endif
  );

  fu_wb_arbiter #(.NrFu(3), .NrWbPorts(1), .BufDepth(2), .DataWidth(64), .TransIdBits(3)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush1),
    .fu_valid_i(f1_valid), .fu_ready_o(f1_ready), .fu_result_i(f1_result),
    .fu_trans_id_i(f1_id), .fu_ex_valid_i(f1_exv), .fu_ex_cause_i(f1_exc),
    .wb_valid_o(w1_valid), .wb_result_o(w1_result), .wb_trans_id_o(w1_id),
    .wb_ex_valid_o(w1_exv), .wb_ex_cause_o(w1_exc), .wb_fu_idx_o(w1_idx)
`ifdef FU_WB_ARB_PERF_EN
    , .wb_conflict_o(conflict1), .wb_conflict_cnt_o(conflict_cnt1)
`endif
  );

  typedef struct {
    logic [3:0]  valid;
    logic [63:0] base;
    logic [1:0]  exp_valid;
    logic [1:0]  exp_idx0;
    logic [1:0]  exp_idx1;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fu(input logic [1:0] n, input logic [63:0] base);
    logic [63:0] d;
    d = base + 64'(n);
    fu_result[n] = d;
    fu_id[n]     = d[2:0];
    fu_exv[n]    = d[0];
    fu_exc[n]    = ~d;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  // Expected fields are rebuilt from the stimulus rule used by set_fu.
  task automatic check_port(input logic p, input logic ev, input logic [1:0] fi,
                            input logic [63:0] base, input string tag);
    logic [63:0] d;
    d = base + 64'(fi);
    chk({tag, "_valid"}, 64'(wb_valid[p]), 64'(ev));
    chk({tag, "_idx"},   64'(wb_idx[p]),   ev ? 64'(fi) : 64'd0);
    chk({tag, "_res"},   wb_result[p],     ev ? d : 64'd0);
    chk({tag, "_id"},    64'(wb_id[p]),    ev ? 64'(d[2:0]) : 64'd0);
    chk({tag, "_exv"},   64'(wb_exv[p]),   ev ? 64'(d[0]) : 64'd0);
    chk({tag, "_exc"},   wb_exc[p],        ev ? ~d : 64'd0);
  endtask

  vec_t vecs [6];
  logic [63:0] q0 [$];
  logic [63:0] exp_val;
  int pushed [3];
  int popped [3];
  int k0, en;
  bit saw_block;

  initial begin
    vecs[0] = '{4'b0010, 64'hDEAC, 2'b01, 2'd1, 2'd0};
    vecs[1] = '{4'b1111, 64'h0,    2'b11, 2'd0, 2'd1};
    vecs[2] = '{4'b1010, 64'h1230, 2'b11, 2'd1, 2'd3};
    vecs[3] = '{4'b1000, 64'h40,   2'b01, 2'd3, 2'd0};
    vecs[4] = '{4'b0101, 64'hA5A0, 2'b11, 2'd0, 2'd2};
    vecs[5] = '{4'b0000, 64'h7,    2'b00, 2'd0, 2'd0};

    rst_ni = 1'b0; flush = 1'b0; flush1 = 1'b0;
    fu_valid = '0; fu_result = '0; fu_id = '0; fu_exv = '0; fu_exc = '0;
    f1_valid = '0; f1_result = '0; f1_id = '0; f1_exv = '0; f1_exc = '0;
    #2;
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_wb_res0", wb_result[0], 64'd0);
    chk("rst_wb_idx", 64'(wb_idx), 64'd0);
    #10 rst_ni = 1'b1;
    tick();
    chk("rst_ready", 64'(fu_ready), 64'hF);
    chk("rst_ready1", 64'(f1_ready), 64'h7);

    // Table: each vector starts from empty FIFOs with rr = 0.
    for (int v = 0; v < 6; v++) begin
      do_flush();
      fu_valid = vecs[v].valid;
      for (int n = 0; n < 4; n++) set_fu(2'(n), vecs[v].base);
      tick();
      fu_valid = '0;
      check_port(1'b0, vecs[v].exp_valid[0], vecs[v].exp_idx0, vecs[v].base, $sformatf("v%0d_p0", v));
      check_port(1'b1, vecs[v].exp_valid[1], vecs[v].exp_idx1, vecs[v].base, $sformatf("v%0d_p1", v));
      if (v == 1) begin
`ifdef FU_WB_ARB_PERF_EN
        chk("perf_conflict", 64'(conflict), 64'd1);
`endif
        tick();
        check_port(1'b0, 1'b1, 2'd2, 64'h0, "cont_c2_p0");
        check_port(1'b1, 1'b1, 2'd3, 64'h0, "cont_c2_p1");
        tick();
        chk("cont_c3_valid", 64'(wb_valid), 64'd0);
        // rr must have wrapped to 0: FU0 outranks FU3.
        fu_valid = 4'b1001;
        for (int n = 0; n < 4; n++) set_fu(2'(n), 64'h80);
        tick();
        fu_valid = '0;
        check_port(1'b0, 1'b1, 2'd0, 64'h80, "cont_rr_p0");
        check_port(1'b1, 1'b1, 2'd3, 64'h80, "cont_rr_p1");
      end
    end

    // Back-pressure: all four FUs push whenever ready; FU0 order is scoreboarded.
    do_flush();
    k0 = 0; en = 0; saw_block = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        if (wb_valid[p] && wb_idx[p] == 2'd0) begin
          en++;
          if (q0.size() == 0) chk("bp_spurious", wb_result[p], 64'hFFFF_FFFF_FFFF_FFFF);
          else chk("bp_order", wb_result[p], q0.pop_front());
        end
      end
      if (!fu_ready[0]) saw_block = 1;
      if (cyc < 20) begin
        fu_valid = fu_ready;
        for (int n = 1; n < 4; n++) set_fu(2'(n), 64'h3000);
        fu_result[0] = 64'h100 + 64'(k0);
        fu_id[0] = 3'(k0);
        if (fu_ready[0]) begin
          q0.push_back(64'h100 + 64'(k0));
          k0++;
        end
      end else begin
        fu_valid = '0;
      end
      tick();
    end
    chk("bp_blocked", 64'(saw_block), 64'd1);
    chk("bp_drained", 64'(q0.size()), 64'd0);
    chk("bp_count", 64'(en), 64'(k0));
    chk("bp_idle", 64'(wb_valid), 64'd0);

    // Fairness on the single-port instance: grants rotate 0,1,2.
    for (int n = 0; n < 3; n++) begin
      pushed[n] = 0;
      popped[n] = 0;
    end
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc >= 1) begin
        int e;
        e = (cyc - 1) % 3;
        chk($sformatf("fair_valid_c%0d", cyc), 64'(w1_valid), 64'd1);
        chk($sformatf("fair_idx_c%0d", cyc), 64'(w1_idx[0]), 64'(e));
        chk($sformatf("fair_res_c%0d", cyc), w1_result[0], 64'(e * 256 + popped[e]));
        popped[e]++;
      end
      for (int n = 0; n < 3; n++) begin
        f1_valid[n]  = f1_ready[n];
        f1_result[n] = 64'(n * 256 + pushed[n]);
        if (f1_ready[n]) pushed[n]++;
      end
      tick();
    end
    f1_valid = '0;

    // Flush with a concurrent push.
    do_flush();
    fu_valid = 4'b0111;
    for (int n = 0; n < 4; n++) set_fu(2'(n), 64'h500);
    tick();
    chk("fl_pre_valid", 64'(wb_valid), 64'd3);
    flush = 1'b1;
    fu_valid = 4'b1000;
    set_fu(2'd3, 64'h600);
    #2 chk("fl_cycle_valid", 64'(wb_valid), 64'd3);
    tick();
    flush = 1'b0;
    fu_valid = '0;
    chk("fl_post_valid", 64'(wb_valid), 64'd0);
    chk("fl_post_ready", 64'(fu_ready), 64'hF);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("fl_no_stale%0d", i), 64'(wb_valid), 64'd0);
    end

    // Asynchronous reset while entries are buffered.
    fu_valid = 4'b1111;
    for (int n = 0; n < 4; n++) set_fu(2'(n), 64'h700);
    tick();
    fu_valid = '0;
    chk("rm_pre_valid", 64'(wb_valid), 64'd3);
    #2 rst_ni = 1'b0;
    #1;
    chk("rm_valid", 64'(wb_valid), 64'd0);
    chk("rm_res0", wb_result[0], 64'd0);
    chk("rm_id1", 64'(wb_id[1]), 64'd0);
`ifdef FU_WB_ARB_PERF_EN
    chk("rm_perf_cnt", 64'(conflict_cnt), 64'd0);
`endif
    @(negedge clk);
    rst_ni = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("rm_no_stale%0d", i), 64'(wb_valid), 64'd0);
    end
    chk("rm_ready", 64'(fu_ready), 64'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
